// File: rtl/instr_buffer_pkg.sv
// Shared types and sizing for the instruction buffer between fetch and dispatch.
// Fetch and dispatch import the same packet layout, so it must stay in step with both.
package instr_buffer_pkg;

  localparam int IB_SZ         = 16;
  localparam int IB_PUSH_WIDTH = 4;
  localparam int IB_POP_WIDTH  = 3;
  localparam int IB_IDX_BITS   = $clog2(IB_SZ);
  localparam int PUSH_CNT_BITS = $clog2(IB_PUSH_WIDTH + 1);
  localparam int POP_CNT_BITS  = $clog2(IB_POP_WIDTH + 1);
  localparam int XLEN          = 32;
  localparam int GHR_BITS      = 8;

  typedef logic [IB_IDX_BITS-1:0]   ib_idx_t;
  typedef logic [IB_IDX_BITS:0]     ib_cnt_t;
  typedef logic [PUSH_CNT_BITS-1:0] push_cnt_t;
  typedef logic [POP_CNT_BITS-1:0]  pop_cnt_t;

  localparam ib_cnt_t  IB_SZ_CNT   = ib_cnt_t'(IB_SZ);
  localparam ib_cnt_t  POP_W_CNT   = ib_cnt_t'(IB_POP_WIDTH);
  localparam pop_cnt_t POP_W_SMALL = pop_cnt_t'(IB_POP_WIDTH);

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     inst;
    logic                is_branch;
    logic                bp_pred_taken;
    logic [XLEN-1:0]     bp_pred_target;
    logic [GHR_BITS-1:0] bp_ghr_snapshot;
  } fetch_packet_t;

  // Entries dispatch may see this cycle: min(occupancy, dispatch width).
  function automatic pop_cnt_t avail_of(input ib_cnt_t count);
    if (count >= POP_W_CNT) return POP_W_SMALL;
    return pop_cnt_t'(count);
  endfunction

endpackage

// File: rtl/instr_buffer_push_compactor.sv
// Prefix-popcount over the fetch lane valid mask: each valid lane gets its slot
// offset from tail, and the popcount is checked against fetch's declared push count.
module ib_push_compactor
  import instr_buffer_pkg::*;
(
  input  logic [IB_PUSH_WIDTH-1:0] lane_valid,
  input  push_cnt_t                num_pushes,
  output ib_idx_t                  lane_offset [IB_PUSH_WIDTH],
  output logic                     count_ok
);

  push_cnt_t running;

  always_comb begin
    running = '0;
    for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
      lane_offset[i] = ib_idx_t'(running);
      running        = running + push_cnt_t'(lane_valid[i]);
    end
    count_ok = (running == num_pushes);
  end

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction buffer: compacts sparse fetch bundles into storage and
// presents the oldest entries to dispatch, with a registered free-slot count back to fetch.
module instr_buffer
  import instr_buffer_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  fetch_packet_t fetch_packet [IB_PUSH_WIDTH],
  input  push_cnt_t     num_pushes,
  output ib_cnt_t       ib_free_slots,
  input  logic          flush,
  output fetch_packet_t dispatch_packets [IB_POP_WIDTH],
  output pop_cnt_t      num_available,
  input  pop_cnt_t      num_pops,
  output logic          overflow_err
);

  // Handshake: a push bundle is accepted whole when its valid-lane popcount equals
  // num_pushes and num_pushes <= ib_free_slots as registered at the start of the cycle;
  // otherwise it is dropped and overflow_err latches. Dispatch may take up to
  // num_available entries; larger requests are clamped and also latch overflow_err.
  // Flush wins over everything in its cycle and leaves overflow_err alone.

  fetch_packet_t storage [IB_SZ];

  ib_idx_t head_q, tail_q;
  ib_cnt_t count_q, free_q;
  logic    overflow_q;

  logic [IB_PUSH_WIDTH-1:0] lane_valid;
  ib_idx_t                  lane_offset [IB_PUSH_WIDTH];
  ib_idx_t                  wr_idx      [IB_PUSH_WIDTH];
  logic                     count_ok;

  pop_cnt_t  avail;
  logic      push_fits, push_ok, push_err, pop_err;
  push_cnt_t push_eff;
  pop_cnt_t  pop_eff;
  ib_cnt_t   count_next;
  ib_idx_t   head_next, tail_next;

  always_comb begin
    for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
      lane_valid[i] = fetch_packet[i].valid;
    end
  end

  ib_push_compactor u_compactor (
    .lane_valid  (lane_valid),
    .num_pushes  (num_pushes),
    .lane_offset (lane_offset),
    .count_ok    (count_ok)
  );

  always_comb begin
    avail     = avail_of(count_q);
    push_fits = (ib_cnt_t'(num_pushes) <= free_q);
    push_ok   = !flush && count_ok && push_fits;
    push_err  = !flush && !(count_ok && push_fits);
    pop_err   = !flush && (num_pops > avail);
    pop_eff   = (num_pops > avail) ? avail : num_pops;
    push_eff  = push_ok ? num_pushes : '0;

    for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
      wr_idx[i] = tail_q + lane_offset[i];
    end

    if (flush) begin
      count_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end else begin
      count_next = count_q + ib_cnt_t'(push_eff) - ib_cnt_t'(pop_eff);
      head_next  = head_q + ib_idx_t'(pop_eff);
      tail_next  = tail_q + ib_idx_t'(push_eff);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      free_q     <= IB_SZ_CNT;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_next;
      tail_q     <= tail_next;
      count_q    <= count_next;
      free_q     <= IB_SZ_CNT - count_next;
      overflow_q <= overflow_q | push_err | pop_err;
    end
  end

  // Storage has no reset; validity is tracked purely by head/count.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
        if (lane_valid[i]) storage[wr_idx[i]] <= fetch_packet[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < IB_POP_WIDTH; j++) begin
      dispatch_packets[j]       = storage[head_q + ib_idx_t'(j)];
      dispatch_packets[j].valid = (pop_cnt_t'(j) < avail);
    end
  end

  assign ib_free_slots = free_q;
  assign num_available = avail;
  assign overflow_err  = overflow_q;

endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- Circular FIFO between the fetch stage and dispatch; the receiving end of the fetch→IB push interface.
- Accepts up to IB_PUSH_WIDTH fetch packets per cycle. Valid lanes may be non-contiguous, so the block compacts them in lane order.
- Presents up to IB_POP_WIDTH oldest packets to dispatch, which consumes a variable count.
- Reports registered free-slot count back to fetch; flushes entirely on mispredict recovery.

Parameters:
- IB_SZ, 16: entry count; must be a power of two ≥ IB_PUSH_WIDTH.
- IB_PUSH_WIDTH, 4: max pushes per cycle (fetch bundle width).
- IB_POP_WIDTH, 3: max pops per cycle (dispatch width).
- IB_IDX_BITS, $clog2(IB_SZ): pointer width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- fetch_packet  in  FETCH_PACKET[IB_PUSH_WIDTH]  lane-ordered packets; .valid marks lanes to write.
- num_pushes  in  $clog2(IB_PUSH_WIDTH+1)  count of valid lanes this cycle.
- ib_free_slots  out  IB_IDX_BITS+1  IB_SZ − occupancy, registered.
- flush  in  1  mispredict recovery; discards all contents.
- dispatch_packets  out  FETCH_PACKET[IB_POP_WIDTH]  oldest entries, slot 0 = oldest.
- num_available  out  $clog2(IB_POP_WIDTH+1)  min(occupancy, IB_POP_WIDTH).
- num_pops  in  $clog2(IB_POP_WIDTH+1)  entries dispatch consumes this cycle.
- overflow_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset==0, async):
  - head=0, tail=0, count=0, overflow_err=0.
  - ib_free_slots=IB_SZ, num_available=0, all dispatch_packets .valid=0.
  - Storage contents are don't-care.
- Storage: IB_SZ-entry register array; head and tail are IB_IDX_BITS wide and wrap modulo IB_SZ naturally; count is IB_IDX_BITS+1 wide.
- Push compaction:
  - Lane i is written to tail + (number of valid lanes below i), mod IB_SZ.
  - Invalid lanes are skipped. Example: valid=0110 writes lane1→tail, lane2→tail+1.
  - tail advances by num_pushes.
  - $countones(valid) ≠ num_pushes is a violation: set overflow_err, write nothing.
- Push legality:
  - num_pushes ≤ ib_free_slots (registered value) is legal.
  - Otherwise the whole bundle is dropped, overflow_err is set, and state is otherwise unchanged.
  - Pops in the same cycle do not enlarge the current cycle's free slots.
- Pop:
  - dispatch_packets[j] = storage[head+j], combinational from registers.
  - .valid = (j < num_available).
  - num_pops > num_available: clamp to num_available and set overflow_err.
  - head advances by the clamped pop count.
- Simultaneous push and pop: count_next = count + pushes − pops. Both occur in one edge, with no bypass: a packet pushed in cycle N is visible to dispatch in cycle N+1 at the earliest.
- Flush (sampled at clock edge):
  - head=tail=count=0; same-cycle pushes and pops are ignored.
  - ib_free_slots=IB_SZ next cycle.
  - overflow_err is not cleared.
- Latency: push→visible 1 cycle; pop→freed slot visible on ib_free_slots 1 cycle.
- Boundaries:
  - Full (count=IB_SZ): free=0; any nonzero push is dropped with error.
  - Empty: num_available=0, all outputs invalid.
  - Wrap: a push bundle or pop window may straddle index IB_SZ−1→0.
- Packet fields (pc, inst, is_branch, bp_pred_taken, bp_pred_target, bp_ghr_snapshot) are stored and returned bit-exact.

Decomposition:
- FETCH_PACKET, IB_SZ, IB_IDX_BITS, IB_PUSH_WIDTH and IB_POP_WIDTH live in sys_defs.svh, shared with stage_fetch and dispatch.
- One combinational sub-module, ib_push_compactor:
  - Computes per-lane write offsets (prefix popcount) and the valid-count check.
  - Keeps the FIFO module focused on pointers and storage.

Test Plan:
- Reset then push valid=1111, num_pushes=4, PCs 0x0,0x4,0x8,0xC → next cycle: num_available=3, dispatch PCs 0x0,0x4,0x8, ib_free_slots=12.
- Push valid=1110 (PCs 0x4,0x8,0xC, num_pushes=3) into empty buffer → entries 0..2 hold 0x4,0x8,0xC in order; free=13.
- Fill to count=14, push 4 → bundle dropped, overflow_err=1, free stays 2; pop 3 → free=5 next cycle.
- head=14, push 4 (PCs 0x100..0x10C), then pop 3 → dispatch shows 0x100,0x104,0x108 across the wrap; remaining entry 0x10C at index 1.
- count=8, flush=1 with simultaneous push 4 and pop 3 → next cycle count=0, free=16, num_available=0, no packet written.
- Drive reset=0 mid-stream, asynchronously between edges, with count=10 → outputs clear immediately (free=16, num_available=0) without waiting for a clock edge.
